// File: rtl/ctrl_pipe_if.sv
// Control-pipe bus: ID-stage decode fields and hazard controls in,
// per-stage EX/M/W control bundles and the halt flag out.
interface ctrl_pipe_if #(
  parameter int ALUOP_W = 4,
  parameter int EXT_W   = 3
);
  logic               id_valid;
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic               funct7_5;
  logic               stall;
  logic               flush;
  logic [2:0]         mode;
  logic               ex_valid;
  logic [2:0]         ex_branch;
  logic [ALUOP_W-1:0] ex_aluop;
  logic               ex_alusrc1;
  logic [1:0]         ex_alusrc2;
  logic               ex_uors;
  logic [1:0]         ex_jump;
  logic               m_valid;
  logic               m_memread;
  logic               m_memwrite;
  logic               m_memtoreg;
  logic [EXT_W-1:0]   m_extmode1;
  logic [EXT_W-1:0]   m_extmode2;
  logic               w_valid;
  logic               w_regwrite;
  logic               w_pc4;
  logic               halted;

  modport master (
    output id_valid, opcode, funct3, funct7_5, stall, flush,
    input  mode, ex_valid, ex_branch, ex_aluop, ex_alusrc1, ex_alusrc2, ex_uors, ex_jump,
           m_valid, m_memread, m_memwrite, m_memtoreg, m_extmode1, m_extmode2,
           w_valid, w_regwrite, w_pc4, halted
  );

  modport slave (
    input  id_valid, opcode, funct3, funct7_5, stall, flush,
    output mode, ex_valid, ex_branch, ex_aluop, ex_alusrc1, ex_alusrc2, ex_uors, ex_jump,
           m_valid, m_memread, m_memwrite, m_memtoreg, m_extmode1, m_extmode2,
           w_valid, w_regwrite, w_pc4, halted
  );
endinterface

// File: rtl/ctrl_pipe.sv
// RV32I pipelined control unit: decodes in ID, carries control through EX/M/W
// with stall/flush bubbles and sticky ECALL halt. CTRL_PIPE_JUMP_EN adds JAL/JALR.
module ctrl_pipe #(
  parameter int ALUOP_W = 4,
  parameter int EXT_W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  ctrl_pipe_if.slave   bus
);
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
`ifdef CTRL_PIPE_JUMP_EN
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
`endif

  // Nested bundles: each stage register carries only what later stages consume.
  typedef struct packed {
    logic valid;
    logic regwrite;
    logic pc4;
  } w_t;

  typedef struct packed {
    w_t               w;
    logic             memread;
    logic             memwrite;
    logic             memtoreg;
    logic [EXT_W-1:0] ext1;
    logic [EXT_W-1:0] ext2;
    logic             ecall;
  } m_t;

  typedef struct packed {
    m_t                 m;
    logic [2:0]         branch;
    logic [ALUOP_W-1:0] aluop;
    logic               alusrc1;
    logic [1:0]         alusrc2;
    logic               uors;
    logic [1:0]         jump;
  } ex_t;

  ex_t        dec, ex_nxt, ex_r;
  m_t         m_r;
  w_t         w_r;
  logic       halted_r;
  logic [2:0] mode_c;
  logic       blk;

  always_comb begin
    dec         = '0;
    dec.m.w.valid = 1'b1;
    mode_c      = 3'd0;
    case (bus.opcode)
      OP_IMM: begin
        mode_c = (bus.funct3 == 3'b001 || bus.funct3 == 3'b101) ? 3'd2 : 3'd1;
        dec.aluop = ALUOP_W'({(bus.funct3 == 3'b101) & bus.funct7_5, bus.funct3});
        dec.alusrc1 = 1'b1;
        dec.m.w.regwrite = 1'b1;
      end
      OP_REG: begin
        dec.aluop = ALUOP_W'({bus.funct7_5, bus.funct3});
        dec.m.w.regwrite = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        mode_c = 3'd3;
        dec.alusrc1 = 1'b1;
        dec.alusrc2 = (bus.opcode == OP_LUI) ? 2'd2 : 2'd1;
        dec.m.w.regwrite = 1'b1;
      end
      OP_BR: begin
        mode_c = 3'd5;
        case (bus.funct3)
          3'b000: begin dec.branch = 3'b010; dec.aluop = ALUOP_W'(4'b0010); end
          3'b001: begin dec.branch = 3'b101; dec.aluop = ALUOP_W'(4'b0010); end
          3'b100: begin dec.branch = 3'b100; dec.aluop = ALUOP_W'(4'b0010); end
          3'b101: begin dec.branch = 3'b011; dec.aluop = ALUOP_W'(4'b0010); end
          3'b110: begin dec.branch = 3'b100; dec.aluop = ALUOP_W'(4'b0011); dec.uors = 1'b1; end
          3'b111: begin dec.branch = 3'b011; dec.aluop = ALUOP_W'(4'b0011); dec.uors = 1'b1; end
          default: ;
        endcase
      end
      OP_LD: begin
        mode_c = 3'd1;
        dec.alusrc1 = 1'b1;
        dec.m.memread = 1'b1;
        dec.m.memtoreg = 1'b1;
        dec.m.w.regwrite = 1'b1;
        case (bus.funct3)
          3'b000:  dec.m.ext1 = EXT_W'(3'b001);
          3'b001:  dec.m.ext1 = EXT_W'(3'b011);
          3'b100:  dec.m.ext1 = EXT_W'(3'b010);
          3'b101:  dec.m.ext1 = EXT_W'(3'b100);
          default: dec.m.ext1 = '0;
        endcase
      end
      OP_ST: begin
        mode_c = 3'd6;
        dec.alusrc1 = 1'b1;
        dec.m.memwrite = 1'b1;
        case (bus.funct3)
          3'b000:  dec.m.ext2 = EXT_W'(3'b010);
          3'b001:  dec.m.ext2 = EXT_W'(3'b100);
          default: dec.m.ext2 = '0;
        endcase
      end
      OP_SYS: dec.m.ecall = 1'b1;
`ifdef CTRL_PIPE_JUMP_EN
      OP_JAL: begin
        mode_c = 3'd4;
        dec.jump = 2'b01;
        dec.alusrc1 = 1'b1;
        dec.alusrc2 = 2'd1;
        dec.m.w.regwrite = 1'b1;
        dec.m.w.pc4 = 1'b1;
      end
      OP_JALR: begin
        mode_c = 3'd1;
        dec.jump = 2'b10;
        dec.alusrc1 = 1'b1;
        dec.m.w.regwrite = 1'b1;
        dec.m.w.pc4 = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Once an ECALL is in flight, younger instructions are kept out of EX so
  // nothing issued behind it executes before the halt lands.
  assign blk    = halted_r | ex_r.m.ecall | m_r.ecall;
  assign ex_nxt = (bus.id_valid && !blk) ? dec : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r     <= '0;
      m_r      <= '0;
      w_r      <= '0;
      halted_r <= 1'b0;
    end else begin
      w_r      <= m_r.w;
      halted_r <= halted_r | m_r.ecall;
      if (bus.stall) begin
        m_r <= '0;
      end else begin
        m_r  <= ex_r.m;
        ex_r <= bus.flush ? '0 : ex_nxt;
      end
    end
  end

  assign bus.mode       = mode_c;
  assign bus.ex_valid   = ex_r.m.w.valid;
  assign bus.ex_branch  = ex_r.branch;
  assign bus.ex_aluop   = ex_r.aluop;
  assign bus.ex_alusrc1 = ex_r.alusrc1;
  assign bus.ex_alusrc2 = ex_r.alusrc2;
  assign bus.ex_uors    = ex_r.uors;
  assign bus.ex_jump    = ex_r.jump;
  assign bus.m_valid    = m_r.w.valid;
  assign bus.m_memread  = m_r.memread;
  assign bus.m_memwrite = m_r.memwrite;
  assign bus.m_memtoreg = m_r.memtoreg;
  assign bus.m_extmode1 = m_r.ext1;
  assign bus.m_extmode2 = m_r.ext2;
  assign bus.w_valid    = w_r.valid;
  assign bus.w_regwrite = w_r.regwrite;
  assign bus.w_pc4      = w_r.pc4;
  assign bus.halted     = halted_r;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: decode, stall/flush, ECALL halt, reset, and
// JAL (expectations follow CTRL_PIPE_JUMP_EN).
module tb_ctrl_pipe;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ctrl_pipe_if #(.ALUOP_W(4), .EXT_W(3)) bus ();

  ctrl_pipe #(.ALUOP_W(4), .EXT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic f7);
    bus.id_valid = v;
    bus.opcode   = op;
    bus.funct3   = f3;
    bus.funct7_5 = f7;
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    issue(1'b0, 7'd0, 3'd0, 1'b0);
    step();
    chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_m_valid",  32'(bus.m_valid), 32'd0);
    chk("rst_w_valid",  32'(bus.w_valid), 32'd0);
    chk("rst_halted",   32'(bus.halted), 32'd0);
    chk("rst_mode",     32'(bus.mode), 32'd0);
    rst = 1'b0;

    // SUB
    issue(1'b1, 7'b0110011, 3'b000, 1'b1);
    step();
    chk("sub_ex_valid", 32'(bus.ex_valid), 32'd1);
    chk("sub_aluop",    32'(bus.ex_aluop), 32'h8);
    chk("sub_alusrc1",  32'(bus.ex_alusrc1), 32'd0);
    issue(1'b0, 7'd0, 3'd0, 1'b0);
    step();
    step();
    chk("sub_w_regwrite", 32'(bus.w_regwrite), 32'd1);
    chk("sub_w_valid",    32'(bus.w_valid), 32'd1);

    // LH
    issue(1'b1, 7'b0000011, 3'b001, 1'b0);
    #1;
    chk("lh_mode", 32'(bus.mode), 32'd1);
    step();
    issue(1'b0, 7'd0, 3'd0, 1'b0);
    step();
    chk("lh_m_memread",  32'(bus.m_memread), 32'd1);
    chk("lh_m_memtoreg", 32'(bus.m_memtoreg), 32'd1);
    chk("lh_m_extmode1", 32'(bus.m_extmode1), 32'h3);

    // Immediate-form decode spot checks
    issue(1'b1, 7'b0010011, 3'b101, 1'b1);
    #1;
    chk("srai_mode", 32'(bus.mode), 32'd2);
    step();
    chk("srai_aluop", 32'(bus.ex_aluop), 32'hd);
    issue(1'b1, 7'b0010011, 3'b000, 1'b1);
    step();
    chk("addi_aluop",   32'(bus.ex_aluop), 32'h0);
    chk("addi_alusrc1", 32'(bus.ex_alusrc1), 32'd1);
    issue(1'b1, 7'b0110111, 3'b000, 1'b0);
    #1;
    chk("lui_mode", 32'(bus.mode), 32'd3);
    step();
    chk("lui_alusrc2", 32'(bus.ex_alusrc2), 32'd2);
    issue(1'b1, 7'b1100011, 3'b001, 1'b0);
    step();
    chk("bne_branch", 32'(bus.ex_branch), 32'h5);
    chk("bne_aluop",  32'(bus.ex_aluop), 32'h2);
    issue(1'b0, 7'd0, 3'd0, 1'b0);
    step();
    step();
    step();

    // Stall: SB held in EX for three cycles, two bubbles into M
    issue(1'b1, 7'b0100011, 3'b000, 1'b0);
    #1;
    chk("sb_mode", 32'(bus.mode), 32'd6);
    step();
    chk("st_ex_valid0", 32'(bus.ex_valid), 32'd1);
    issue(1'b0, 7'd0, 3'd0, 1'b0);
    bus.stall = 1'b1;
    step();
    chk("st_ex_valid1", 32'(bus.ex_valid), 32'd1);
    chk("st_m_valid1",  32'(bus.m_valid), 32'd0);
    chk("st_m_memwr1",  32'(bus.m_memwrite), 32'd0);
    step();
    chk("st_ex_valid2", 32'(bus.ex_valid), 32'd1);
    chk("st_m_valid2",  32'(bus.m_valid), 32'd0);
    bus.stall = 1'b0;
    step();
    chk("st_m_memwrite", 32'(bus.m_memwrite), 32'd1);
    chk("st_m_extmode2", 32'(bus.m_extmode2), 32'h2);
    chk("st_ex_valid3",  32'(bus.ex_valid), 32'd0);

    // Stall+flush: stall wins, then flush alone bubbles EX
    issue(1'b1, 7'b1100011, 3'b110, 1'b0);
    step();
    chk("bltu_aluop", 32'(bus.ex_aluop), 32'h3);
    issue(1'b0, 7'd0, 3'd0, 1'b0);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    step();
    chk("sf_ex_branch", 32'(bus.ex_branch), 32'h4);
    chk("sf_ex_uors",   32'(bus.ex_uors), 32'd1);
    chk("sf_ex_valid",  32'(bus.ex_valid), 32'd1);
    bus.stall = 1'b0;
    step();
    chk("fl_ex_valid",  32'(bus.ex_valid), 32'd0);
    chk("fl_ex_branch", 32'(bus.ex_branch), 32'd0);
    chk("fl_m_valid",   32'(bus.m_valid), 32'd1);
    bus.flush = 1'b0;
    step();
    step();

    // ECALL then ADDI stream
    issue(1'b1, 7'b1110011, 3'b000, 1'b0);
    step();
    chk("ec_ex_valid", 32'(bus.ex_valid), 32'd1);
    chk("ec_halted0",  32'(bus.halted), 32'd0);
    issue(1'b1, 7'b0010011, 3'b000, 1'b0);
    step();
    chk("ec_addi_blk1", 32'(bus.ex_valid), 32'd0);
    chk("ec_halted1",   32'(bus.halted), 32'd0);
    step();
    chk("ec_halted2", 32'(bus.halted), 32'd1);
    chk("ec_w_valid", 32'(bus.w_valid), 32'd1);
    chk("ec_addi_blk2", 32'(bus.ex_valid), 32'd0);
    step();
    step();
    chk("ec_halted_sticky", 32'(bus.halted), 32'd1);
    chk("ec_addi_blk3",     32'(bus.ex_valid), 32'd0);
    chk("ec_w_regwrite",    32'(bus.w_regwrite), 32'd0);
    rst = 1'b1;
    issue(1'b0, 7'd0, 3'd0, 1'b0);
    step();
    chk("rst2_halted", 32'(bus.halted), 32'd0);
    chk("rst2_bundle", {bus.ex_valid, bus.m_valid, bus.w_valid, bus.ex_aluop,
                        bus.m_memread, bus.w_regwrite}, 32'd0);
    rst = 1'b0;

    // JAL
    issue(1'b1, 7'b1101111, 3'b000, 1'b0);
    #1;
`ifdef CTRL_PIPE_JUMP_EN
    chk("jal_mode", 32'(bus.mode), 32'd4);
`else
    chk("jal_mode", 32'(bus.mode), 32'd0);
`endif
    step();
    issue(1'b0, 7'd0, 3'd0, 1'b0);
`ifdef CTRL_PIPE_JUMP_EN
    chk("jal_ex_jump",    32'(bus.ex_jump), 32'h1);
    chk("jal_ex_alusrc2", 32'(bus.ex_alusrc2), 32'd1);
`else
    chk("jal_ex_jump",    32'(bus.ex_jump), 32'h0);
    chk("jal_ex_alusrc2", 32'(bus.ex_alusrc2), 32'd0);
`endif
    step();
    step();
`ifdef CTRL_PIPE_JUMP_EN
    chk("jal_w_pc4",      32'(bus.w_pc4), 32'd1);
    chk("jal_w_regwrite", 32'(bus.w_regwrite), 32'd1);
`else
    chk("jal_w_pc4",      32'(bus.w_pc4), 32'd0);
    chk("jal_w_regwrite", 32'(bus.w_regwrite), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Parametrised pipelined control unit for the RV32I core. It decodes opcode/funct3/funct7[5] in ID and carries the control bundle through EX, M and W stage registers. It adds per-stage valid tracking, stall/flush bubble insertion, full ALU-op encoding (SUB/SRA) and a sticky ECALL halt. It sits between the instruction register and the datapath; the datapath reads each stage's outputs directly.

## Interface
- `ALUOP_W`, default 4: ALU-op width; bit 3 = funct7[5] qualifier, bits 2:0 = funct3. Must be ≥ 4.
- `EXT_W`, default 3: load/store extension-mode width.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `id_valid` in 1: ID holds a real instruction; 0 means bubble.
- `opcode` in 7, `funct3` in 3, `funct7_5` in 1: ID fields.
- `stall` in 1: hold EX, bubble into M.
- `flush` in 1: bubble into EX.
- `mode` out 3: combinational immediate-format select. R=0, I=1, shift-I=2, U=3, J=4, B=5, S=6, unknown=0.
- `ex_valid` out 1, `ex_branch` out 3, `ex_aluop` out ALUOP_W, `ex_alusrc1` out 1, `ex_alusrc2` out 2, `ex_uors` out 1, `ex_jump` out 2: EX stage.
- `m_valid` out 1, `m_memread` out 1, `m_memwrite` out 1, `m_memtoreg` out 1, `m_extmode1` out EXT_W, `m_extmode2` out EXT_W: M stage.
- `w_valid` out 1, `w_regwrite` out 1, `w_pc4` out 1: W stage (`w_pc4` selects PC+4 writeback).
- `halted` out 1: sticky stop.

## Operation
- Decode table:
  - ADDI family: aluop={funct7_5 if funct3=101 else 0, funct3}; alusrc1=1; regwrite=1.
  - ADD family: aluop={funct7_5, funct3}; alusrc1=0; regwrite=1.
  - LUI: alusrc1=1, alusrc2=2. AUIPC: alusrc1=1, alusrc2=1. Both: aluop=0, regwrite=1.
  - Branch, alusrc1=0, regwrite=0:
    - BEQ: branch=010, aluop=0010.
    - BNE: branch=101, aluop=0010.
    - BLT: branch=100, aluop=0010.
    - BGE: branch=011, aluop=0010.
    - BLTU: branch=100, aluop=0011, uors=1.
    - BGEU: branch=011, aluop=0011, uors=1.
    - Other funct3: branch=0, aluop=0.
  - Load: memread=1, memtoreg=1, regwrite=1, alusrc1=1. extmode1: LB=001, LH=011, LW=000, LBU=010, LHU=100, else 000.
  - Store: memwrite=1, alusrc1=1. extmode2: SB=010, SH=100, else 000.
  - ECALL (1110011): internal ecall flag only.
  - Any other opcode: all zero.
- Bubble = every control field 0, valid=0, ecall flag=0.
- Pipeline advance:
  - Normal: EX←decode (bubble if !id_valid or halted); M←EX fields; W←M fields.
  - stall=1: EX holds; M←bubble; W←M.
  - flush=1 with stall=0: EX←bubble; M←EX; W←M.
  - stall and flush together: stall wins and flush is ignored. The hazard unit re-asserts flush.
- Halt: `halted` sets on the edge that loads an ECALL into W. It stays set until rst. While halted, EX loads only bubbles and the remaining stages drain normally.
- Reset: every output 0 (all stage fields, valids, halted) on the first rising edge with rst=1. This overrides stall/flush and aborts in-flight instructions.

## Timing
- `mode` is combinational from the current opcode/funct3.
- Instruction in ID at edge N (no stall/flush) → EX outputs valid after N, M after N+1, W after N+2.
- ECALL decoded at edge N → `halted`=1 after N+2, same cycle `w_valid`=1.
- Each stall cycle adds one cycle of latency to the held instruction's M/W arrival.

## Configuration
- `CTRL_PIPE_JUMP_EN` defined:
  - JAL (1101111): mode=4, ex_jump=01, alusrc1=1, alusrc2=1, regwrite=1, w_pc4=1.
  - JALR (1100111): mode=1, ex_jump=10, alusrc1=1, alusrc2=0, regwrite=1, w_pc4=1.
- Undefined: both opcodes decode as unknown (all zero, mode=0); ex_jump and w_pc4 are tied to 0.

## Test plan
- SUB: rst 1 cycle; then opcode=0110011, funct3=000, funct7_5=1, id_valid=1 → next cycle ex_aluop=1000, ex_alusrc1=0; two cycles later w_regwrite=1.
- LH: opcode=0000011, funct3=001 → mode=1 immediately; after 2 edges m_memread=1, m_memtoreg=1, m_extmode1=011.
- Stall: issue SB (0100011/000) with stall=1 for 2 cycles → ex_* held 3 cycles; M sees 2 bubbles then m_memwrite=1, m_extmode2=010.
- Stall+flush: BLTU in EX, stall=flush=1 one cycle → EX keeps branch=100, uors=1; next cycle flush alone → ex_valid=0.
- ECALL: ECALL followed by ADDI stream → halted=1 two edges after decode; the ADDIs never reach EX; rst=1 → halted=0, all outputs 0.
- JAL with macro defined: opcode=1101111 → mode=4, ex_jump=01, w_pc4=1 at W. Without the macro: mode=0, all zero.
